// File: rtl/aes_pkg.sv
// Shared AES types and constants for the SubBytes engine.
package aes_pkg;

  localparam int unsigned AES_STATE_BYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_bytes_state_e;

endpackage

// File: rtl/aes_sub_bytes_seq_if.sv
// Handshake bundle for aes_sub_bytes_seq. The master drives the input state and
// accepts the result; the slave is the engine. SUBBYTES_INV_EN adds the inv select.
interface aes_sub_bytes_seq_if;
  logic                in_valid;
  logic                in_ready;
  aes_pkg::aes_state_t in_state;
  logic                out_valid;
  logic                out_ready;
  aes_pkg::aes_state_t out_state;
  logic                busy;
`ifdef SUBBYTES_INV_EN
  logic                inv;
`endif

  modport master (
`ifdef SUBBYTES_INV_EN
    output inv,
`endif
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
`ifdef SUBBYTES_INV_EN
    input  inv,
`endif
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/aes_sbox_fwd.sv
// Forward FIPS-197 S-box. Rows are selected by the high nibble; the low nibble
// picks the column, leftmost byte of a row being column 0.
module aes_sbox_fwd
  import aes_pkg::*;
(
  input  aes_byte_t i_byte,
  output aes_byte_t o_byte
);

  logic [127:0] w_row;

  // Table row lookup; all 16 rows listed, so every input has a defined output.
  always_comb begin
    w_row = '0;
    unique case (i_byte[7:4])
      4'h0: w_row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: w_row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: w_row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: w_row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: w_row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: w_row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: w_row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: w_row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: w_row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: w_row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: w_row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: w_row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: w_row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: w_row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: w_row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: w_row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
  end

  // Column 0 sits in the top byte of the row, hence the inverted low nibble.
  assign o_byte = w_row[{~i_byte[3:0], 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox_inv.sv
// Inverse FIPS-197 S-box, present only when SUBBYTES_INV_EN is defined.
// Same row/column layout as aes_sbox_fwd.
`ifdef SUBBYTES_INV_EN
module aes_sbox_inv
  import aes_pkg::*;
(
  input  aes_byte_t i_byte,
  output aes_byte_t o_byte
);

  logic [127:0] w_row;

  // Table row lookup; all 16 rows listed.
  always_comb begin
    w_row = '0;
    unique case (i_byte[7:4])
      4'h0: w_row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: w_row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: w_row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: w_row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: w_row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: w_row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: w_row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: w_row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: w_row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: w_row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: w_row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: w_row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: w_row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: w_row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: w_row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: w_row = 128'h172b047eba77d626e169146355210c7d;
    endcase
  end

  assign o_byte = w_row[{~i_byte[3:0], 3'b000} +: 8];

endmodule
`endif

// File: rtl/aes_sub_bytes_seq.sv
// Iterative AES SubBytes engine: substitutes BYTES_PER_CYCLE bytes per clock,
// byte 0 (bits 127:120) first. Optional macro SUBBYTES_INV_EN adds a per-transaction
// inv select that switches every lane to the inverse S-box.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input logic                clk,
  input logic                rst,
  aes_sub_bytes_seq_if.slave bus
);

  if (!(BYTES_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Index of the final group; for 16 lanes the step truncates to 0 so the index stays put.
  localparam logic [3:0] LastIdx = 4'(AES_STATE_BYTES - BYTES_PER_CYCLE);
  localparam logic [3:0] IdxStep = 4'(BYTES_PER_CYCLE);

  sub_bytes_state_e r_fsm;
  logic [3:0]       r_idx;
  aes_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef SUBBYTES_INV_EN
  logic             r_inv;
`endif

  aes_byte_t  w_lane_in  [BYTES_PER_CYCLE];
  aes_byte_t  w_lane_out [BYTES_PER_CYCLE];
  aes_state_t w_state_sub;

  // Pick the bytes of the current group out of the state register.
  always_comb begin
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      w_lane_in[k] = r_state[7'(8 * (15 - (int'(r_idx) + k))) +: 8];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    aes_byte_t w_fwd;
    aes_sbox_fwd u_sbox_fwd (
      .i_byte (w_lane_in[g]),
      .o_byte (w_fwd)
    );
`ifdef SUBBYTES_INV_EN
    aes_byte_t w_inv;
    aes_sbox_inv u_sbox_inv (
      .i_byte (w_lane_in[g]),
      .o_byte (w_inv)
    );
    assign w_lane_out[g] = r_inv ? w_inv : w_fwd;
`else
    assign w_lane_out[g] = w_fwd;
`endif
  end

  // Write the substituted group back into a copy of the state.
  always_comb begin
    w_state_sub = r_state;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      w_state_sub[7'(8 * (15 - (int'(r_idx) + k))) +: 8] = w_lane_out[k];
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_idx       <= '0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SUBBYTES_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      unique case (r_fsm)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_state    <= bus.in_state;
            r_idx      <= '0;
            r_fsm      <= BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef SUBBYTES_INV_EN
            r_inv      <= bus.inv;
`endif
          end
        end
        BUSY: begin
          r_state <= w_state_sub;
          r_idx   <= r_idx + IdxStep;
          if (r_idx == LastIdx) begin
            r_idx       <= '0;
            r_fsm       <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_fsm       <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_state;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: three engines (1, 4 and 16 lanes) share
// stimulus; one is selected at a time for driving and monitoring.
module tb_aes_sub_bytes_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_sub_bytes_seq_if if1 ();
  aes_sub_bytes_seq_if if4 ();
  aes_sub_bytes_seq_if if16 ();

  logic [2:0] sel_valid;
  aes_state_t drv_state;
  logic       drv_ready;
  int         sel;

  assign if1.in_valid   = sel_valid[0];
  assign if4.in_valid   = sel_valid[1];
  assign if16.in_valid  = sel_valid[2];
  assign if1.in_state   = drv_state;
  assign if4.in_state   = drv_state;
  assign if16.in_state  = drv_state;
  assign if1.out_ready  = drv_ready;
  assign if4.out_ready  = drv_ready;
  assign if16.out_ready = drv_ready;
`ifdef SUBBYTES_INV_EN
  logic drv_inv;
  assign if1.inv  = drv_inv;
  assign if4.inv  = drv_inv;
  assign if16.inv = drv_inv;
`endif

  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  logic       mon_in_ready, mon_out_valid, mon_busy;
  aes_state_t mon_out_state;

  always_comb begin
    mon_in_ready  = if1.in_ready;
    mon_out_valid = if1.out_valid;
    mon_out_state = if1.out_state;
    mon_busy      = if1.busy;
    case (sel)
      1: begin
        mon_in_ready  = if4.in_ready;
        mon_out_valid = if4.out_valid;
        mon_out_state = if4.out_state;
        mon_busy      = if4.busy;
      end
      2: begin
        mon_in_ready  = if16.in_ready;
        mon_out_valid = if16.out_valid;
        mon_out_state = if16.out_state;
        mon_busy      = if16.busy;
      end
      default: ;
    endcase
  end

  // FIPS-197 forward S-box, row-major by input byte value.
  byte unsigned sbox_ref [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam aes_state_t Vec1 = 128'h00112233445566778899aabbccddeeff;
  localparam aes_state_t Res1 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Full transaction on engine idx with out_ready held high. Checks latency,
  // result, in_ready low and busy high while substituting, and return to idle.
  task automatic txn(input int idx, input aes_state_t st, input aes_state_t exp,
                     input int lat, input string tag);
    int   edges;
    logic bad_rdy, bad_busy;
    sel            = idx;
    drv_state      = st;
    drv_ready      = 1'b1;
    sel_valid[idx] = 1'b1;
    @(posedge clk); #1;
    sel_valid = '0;
    drv_state = ~st;
    edges     = 0;
    bad_rdy   = 1'b0;
    bad_busy  = 1'b0;
    while (!mon_out_valid && edges < 40) begin
      if (mon_in_ready) bad_rdy = 1'b1;
      if (!mon_busy) bad_busy = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, "_lat"}, 128'(edges), 128'(lat));
    check_eq({tag, "_state"}, mon_out_state, exp);
    check_eq({tag, "_rdy_busy"}, 128'(bad_rdy), 128'(0));
    check_eq({tag, "_busy_flag"}, 128'(bad_busy), 128'(0));
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, {mon_in_ready, mon_out_valid}, 128'b10);
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 0;
    sel_valid = '0;
    drv_state = '0;
    drv_ready = 1'b1;
`ifdef SUBBYTES_INV_EN
    drv_inv   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 128'(mon_in_ready), 128'(1));
    check_eq("rst_out_valid", 128'(mon_out_valid), 128'(0));
    check_eq("rst_busy", 128'(mon_busy), 128'(0));
    check_eq("rst_out_state", mon_out_state, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference vector and uniform-byte states.
    txn(0, Vec1, Res1, 16, "t1");
    txn(0, {16{8'h00}}, {16{8'h63}}, 16, "all00");
    txn(0, {16{8'h53}}, {16{8'hed}}, 16, "all53");
    txn(0, {16{8'hff}}, {16{8'h16}}, 16, "allff");

    // Lane 0 sweep; the other bytes stay 00 and map to 63.
    for (int b = 0; b < 256; b++) begin
      txn(0, {8'(b), 120'h0}, {8'(sbox_ref[b]), {15{8'h63}}}, 16, $sformatf("sweep%02h", b));
    end

    // Wider engines on the reference vector.
    txn(1, Vec1, Res1, 4, "bpc4");
    txn(2, Vec1, Res1, 1, "bpc16");

    // Backpressure in DONE while in_valid/in_state toggle.
    sel          = 0;
    drv_ready    = 1'b0;
    drv_state    = Vec1;
    sel_valid[0] = 1'b1;
    @(posedge clk); #1;
    sel_valid = '0;
    repeat (16) @(posedge clk);
    #1;
    check_eq("bp_valid", 128'(mon_out_valid), 128'(1));
    for (int c = 0; c < 10; c++) begin
      sel_valid[0] = ~sel_valid[0];
      drv_state    = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check_eq("bp_state", mon_out_state, Res1);
      check_eq("bp_hold", {mon_out_valid, mon_in_ready}, 128'b10);
    end
    sel_valid = '0;
    drv_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release", {mon_out_valid, mon_in_ready}, 128'b01);

    // Reset on BUSY edge 7 discards the transaction.
    drv_state    = Vec1;
    sel_valid[0] = 1'b1;
    @(posedge clk); #1;
    sel_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_rdy", {mon_in_ready, mon_out_valid, mon_busy}, 128'b100);
    check_eq("mid_rst_state", mon_out_state, 128'h0);
    txn(0, Vec1, Res1, 16, "post_rst");

`ifdef SUBBYTES_INV_EN
    drv_inv = 1'b1;
    txn(0, Res1, Vec1, 16, "inv1");
    txn(2, Res1, Vec1, 1, "inv16");
    drv_inv = 1'b0;
    txn(0, Vec1, Res1, 16, "fwd_after_inv");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
